// File: rtl/f1_pkg.sv
// f1_sweep shared types: FSM state encoding, minterm sizing, popcount.
// Imported by f1_sweep and f1_rail_drv.
package f1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int IDX_W     = 4;
   localparam int N_MINTERM = 16;

   function automatic logic [4:0] popcount16(
      input logic [N_MINTERM-1:0] v
   );
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < N_MINTERM; i++)
         n = n + {4'd0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/f1_rail_drv.sv
// Dual-rail driver: holds the minterm index and drives true/complement rails.
// Ports: clk, rst_n, i_idx_nxt (next index), o_idx (current index), o_a..o_d2 rails.
module f1_rail_drv
   import f1_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] i_idx_nxt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_a,
   output logic             o_a2,
   output logic             o_b,
   output logic             o_b2,
   output logic             o_c,
   output logic             o_c2,
   output logic             o_d,
   output logic             o_d2
);

   logic [IDX_W-1:0] r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_idx <= '0;
      else
         r_idx <= i_idx_nxt;
   end

   // Both rails come off the same flop, so a pair can never agree.
   assign o_idx = r_idx;
   assign o_a   = r_idx[3];
   assign o_a2  = ~r_idx[3];
   assign o_b   = r_idx[2];
   assign o_b2  = ~r_idx[2];
   assign o_c   = r_idx[1];
   assign o_c2  = ~r_idx[1];
   assign o_d   = r_idx[0];
   assign o_d2  = ~r_idx[0];

endmodule

// File: rtl/f1_sweep.sv
// Exhaustive 16-minterm sweep of the f1 cell with truth-table capture and compare.
// Ports: clk, rst_n, start, expected, f_in in; a..d2 rails, busy, done, truth, mismatch, err_cnt, xz_seen out.
module f1_sweep
   import f1_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N_MINTERM-1:0] expected,
   input  logic                 f_in,
   output logic                 a,
   output logic                 a2,
   output logic                 b,
   output logic                 b2,
   output logic                 c,
   output logic                 c2,
   output logic                 d,
   output logic                 d2,
   output logic                 busy,
   output logic                 done,
   output logic [N_MINTERM-1:0] truth,
   output logic                 mismatch,
   output logic [4:0]           err_cnt,
   output logic                 xz_seen
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MINTERM - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [N_MINTERM-1:0] r_truth;
   logic [N_MINTERM-1:0] w_truth_nxt;
   logic [N_MINTERM-1:0] r_exp;
   logic                 r_mis;
   logic [4:0]           r_err;
   logic                 r_xz;
   logic                 w_smp;
   logic                 w_xz;
   logic                 w_accept;

   f1_rail_drv u_rail (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_idx_nxt (w_idx_nxt),
      .o_idx     (w_idx),
      .o_a       (a),
      .o_a2      (a2),
      .o_b       (b),
      .o_b2      (b2),
      .o_c       (c),
      .o_c2      (c2),
      .o_d       (d),
      .o_d2      (d2)
   );

   // Only a clean 1 counts as true; X/Z is flagged and stored as 0.
   assign w_smp    = (f_in === 1'b1);
   assign w_xz     = (f_in !== 1'b0) && (f_in !== 1'b1);
   assign w_accept = (r_state == ST_IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = w_idx;
      w_truth_nxt = r_truth;
      w_truth_nxt[w_idx] = w_smp;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_SAMPLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (w_idx == IDX_LAST) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_idx_nxt   = w_idx + IDX_W'(1);
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_truth <= '0;
         r_exp   <= '0;
         r_mis   <= 1'b0;
         r_err   <= '0;
         r_xz    <= 1'b0;
      end else if (w_accept) begin
         r_truth <= '0;
         r_exp   <= expected;
         r_mis   <= 1'b0;
         r_err   <= '0;
         r_xz    <= 1'b0;
      end else if (r_state == ST_SAMPLE) begin
         r_truth <= w_truth_nxt;
         if (w_xz)
            r_xz <= 1'b1;
         // Compare on the final sample so results are ready with done.
         if (w_idx == IDX_LAST) begin
            r_mis <= (w_truth_nxt != r_exp);
            r_err <= popcount16(w_truth_nxt ^ r_exp);
         end
      end
   end

   assign busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign done     = (r_state == ST_DONE);
   assign truth    = r_truth;
   assign mismatch = r_mis;
   assign err_cnt  = r_err;
   assign xz_seen  = r_xz;

endmodule

// File: tb/tb_f1_sweep.sv
// Directed bench for f1_sweep: SETTLE=2 and SETTLE=1 instances, cell model on f_in.
// Ports: none (top-level bench).
module tb_f1_sweep;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   int          mode = 0;
   logic [15:0] expected = 16'h55AA;
   logic        f0;
   logic        f1v;
   logic        zt;
   logic        exp_xz;
   int          checks = 0;
   int          fails = 0;

   wire [3:0]  r0, n0, r1, n1;
   wire        busy0, done0, mis0, xz0;
   wire        busy1, done1, mis1, xz1;
   wire [15:0] truth0, truth1;
   wire [4:0]  err0, err1;

   wire        start0 = start & ~sel;
   wire        start1 = start & sel;
   wire [3:0]  vi     = sel ? r1 : r0;
   wire [3:0]  vn     = sel ? n1 : n0;
   wire        vbusy  = sel ? busy1 : busy0;
   wire        vdone  = sel ? done1 : done0;
   wire [15:0] vtruth = sel ? truth1 : truth0;
   wire        vmis   = sel ? mis1 : mis0;
   wire [4:0]  verr   = sel ? err1 : err0;
   wire        vxz    = sel ? xz1 : xz0;

   always #5 clk = ~clk;

   function automatic logic fm(input logic [3:0] i, input int m);
      if (m == 1)
         return (i == 4'd6) ? 1'bz : 1'b1;
      return i[3] ^ i[0];
   endfunction

   always_comb f0  = fm(r0, mode);
   always_comb f1v = fm(r1, mode);

   f1_sweep #(.SETTLE(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .expected(expected), .f_in(f0),
      .a(r0[3]), .a2(n0[3]), .b(r0[2]), .b2(n0[2]),
      .c(r0[1]), .c2(n0[1]), .d(r0[0]), .d2(n0[0]),
      .busy(busy0), .done(done0), .truth(truth0),
      .mismatch(mis0), .err_cnt(err0), .xz_seen(xz0)
   );

   f1_sweep #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .expected(expected), .f_in(f1v),
      .a(r1[3]), .a2(n1[3]), .b(r1[2]), .b2(n1[2]),
      .c(r1[1]), .c2(n1[1]), .d(r1[0]), .d2(n1[0]),
      .busy(busy1), .done(done1), .truth(truth1),
      .mismatch(mis1), .err_cnt(err1), .xz_seen(xz1)
   );

   task automatic chk(input string tg, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("rail0", {28'd0, r0 ^ n0}, 32'hF);
      chk("rail1", {28'd0, r1 ^ n1}, 32'hF);
   end

   task automatic chk_rst(input string tg);
      chk({tg, "_true"}, vi, 4'h0);
      chk({tg, "_comp"}, vn, 4'hF);
      chk({tg, "_busy"}, vbusy, 0);
      chk({tg, "_done"}, vdone, 0);
      chk({tg, "_truth"}, vtruth, 0);
      chk({tg, "_mis"}, vmis, 0);
      chk({tg, "_err"}, verr, 0);
      chk({tg, "_xz"}, vxz, 0);
   endtask

   task automatic wait_idx(input logic [3:0] k, input string tg);
      int n = 0;
      while (vi !== k && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tg, vi, k);
   endtask

   task automatic sweep(input int s, input string tg,
                        input logic [15:0] ev, input logic [15:0] et,
                        input logic em, input logic [4:0] ee,
                        input logic ex);
      @(negedge clk);
      expected = ev;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      expected = ~ev;
      chk({tg, "_busy"}, vbusy, 1);
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j <= s; j++) begin
            chk({tg, "_idx"}, vi, k[3:0]);
            chk({tg, "_early"}, vdone, 0);
            @(posedge clk); #1;
         end
      end
      chk({tg, "_done"}, vdone, 1);
      chk({tg, "_bsy0"}, vbusy, 0);
      chk({tg, "_truth"}, vtruth, et);
      chk({tg, "_mis"}, vmis, em);
      chk({tg, "_err"}, verr, ee);
      chk({tg, "_xz"}, vxz, ex);
      @(posedge clk); #1;
      chk({tg, "_pulse"}, vdone, 0);
      chk({tg, "_hold"}, vi, 4'hF);
   endtask

   initial begin
      int nd;
      int last;
      zt = 1'bz;
      exp_xz = $isunknown(zt);
      repeat (3) @(posedge clk);
      #1;
      chk_rst("rst");
      @(negedge clk);
      rst_n = 1'b1;

      sweep(2, "ok", 16'h55AA, 16'h55AA, 1'b0, 5'd0, 1'b0);
      sweep(2, "mis", 16'h55AB, 16'h55AA, 1'b1, 5'd1, 1'b0);
      sel = 1'b1;
      sweep(1, "s1", 16'h55AA, 16'h55AA, 1'b0, 5'd0, 1'b0);
      sel = 1'b0;
      mode = 1;
      sweep(2, "xz", 16'hFFFF, 16'hFFBF, 1'b1, 5'd1, exp_xz);
      mode = 0;

      @(negedge clk);
      expected = 16'h55AA;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idx(4'd4, "ab_w4");
      chk("ab_t4", vtruth, 16'h000A);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ab_norst", vi, 4'd4);
      chk("ab_busy", vbusy, 1);
      wait_idx(4'd9, "ab_w9");
      chk("ab_t9", vtruth, 16'h01AA);
      #2 rst_n = 1'b0;
      #1 chk_rst("ab_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (vdone || vbusy)
            nd++;
      end
      chk("ab_nodone", nd, 0);

      @(negedge clk);
      start = 1'b1;
      nd = 0;
      last = -10;
      for (int n = 0; n < 111; n++) begin
         @(posedge clk); #1;
         if (n == last + 1) begin
            chk("b2b_fall", vdone, 0);
            chk("b2b_idle", {vbusy, vi}, {1'b0, 4'hF});
         end
         if (n == last + 2)
            chk("b2b_idx0", {vbusy, vi}, {1'b1, 4'h0});
         if (vdone) begin
            chk("b2b_truth", vtruth, 16'h55AA);
            nd++;
            last = n;
         end
      end
      chk("b2b_cnt", nd, 2);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
